// File: rtl/rast_mem_pkg.sv
// rast_mem_pkg: shared Avalon widths, clear value and responder state type for the rasterizer memory path
package rast_mem_pkg;
  localparam int AV_ADDR_W = 26;
  localparam int AV_DATA_W = 32;
  localparam int AV_BE_W = 4;
  localparam logic [AV_DATA_W-1:0] CLEAR_VALUE_DEF = 32'h7FFF_FFFF;
  typedef enum logic [1:0] {CLEAR, READY, DRAIN} mem_state_t;
endpackage

// File: rtl/mem_read_pipe.sv
// mem_read_pipe: fixed-latency read valid/data shift register with in-flight counter and held readdata
module mem_read_pipe import rast_mem_pkg::*; #(
  parameter int LATENCY = 2,
  parameter int MAX_PENDING = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               push,
  input  logic [AV_DATA_W-1:0]               push_data,
  output logic                               readdatavalid,
  output logic [AV_DATA_W-1:0]               readdata,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending
);
  localparam int CW = $clog2(MAX_PENDING + 1);
  logic [LATENCY-1:0] v_q, v_nxt;
  logic [AV_DATA_W-1:0] d_q [LATENCY];
  logic [AV_DATA_W-1:0] d_in [LATENCY];
  assign v_nxt = LATENCY'({v_q, push});
  always_comb begin
    d_in[0] = push_data;
    for (int i = 1; i < LATENCY; i++) d_in[i] = d_q[i-1];
  end
  always_ff @(posedge clock)
    if (reset) begin
      v_q <= '0;
      pending <= '0;
      for (int i = 0; i < LATENCY; i++) d_q[i] <= '0;
    end else begin
      v_q <= v_nxt;
      pending <= pending + CW'(push) - CW'(v_nxt[LATENCY-1]);
      for (int i = 0; i < LATENCY; i++) if (i < LATENCY - 1 || v_nxt[i]) d_q[i] <= d_in[i];
    end
  assign readdatavalid = v_q[LATENCY-1];
  assign readdata = d_q[LATENCY-1];
endmodule

// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder: Avalon-MM word RAM slave with pipelined reads, byte-enabled writes and bulk clear
module avalon_mem_responder import rast_mem_pkg::*; #(
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING = 2,
  parameter logic [AV_DATA_W-1:0] CLEAR_VALUE = CLEAR_VALUE_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [AV_ADDR_W-1:0] slave_address,
  input  logic                 slave_read,
  input  logic                 slave_write,
  input  logic [AV_BE_W-1:0]   slave_byteenable,
  input  logic [AV_DATA_W-1:0] slave_writedata,
  output logic [AV_DATA_W-1:0] slave_readdata,
  output logic                 slave_readdatavalid,
  output logic                 slave_waitrequest,
  input  logic                 force_wait,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 err_sticky
);
  localparam int CW = $clog2(MAX_PENDING + 1);
  mem_state_t state;
  logic [DEPTH_LOG2-1:0] ptr, idx;
  logic [AV_DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [CW-1:0] pending;
  logic oor, both, rd_acc, wr_acc, unused_lsb;
  assign idx = slave_address[DEPTH_LOG2+1:2];
  assign oor = |slave_address[AV_ADDR_W-1:DEPTH_LOG2+2];
  assign both = slave_read & slave_write;
  assign slave_waitrequest = (state != READY) | force_wait | (slave_read & (pending == CW'(MAX_PENDING)));
  assign rd_acc = slave_read & ~slave_waitrequest;
  assign wr_acc = slave_write & ~slave_waitrequest;
  assign clear_busy = state != READY;
  assign unused_lsb = ^slave_address[1:0];
  always_ff @(posedge clock)
    if (state == CLEAR) mem[ptr] <= CLEAR_VALUE;
    else if (wr_acc & ~slave_read & ~oor & ~reset)
      for (int b = 0; b < AV_BE_W; b++) if (slave_byteenable[b]) mem[idx][8*b +: 8] <= slave_writedata[8*b +: 8];
  always_ff @(posedge clock)
    if (reset) begin
      state <= CLEAR;
      ptr <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        ptr <= ptr + DEPTH_LOG2'(1);
        if (&ptr) state <= READY;
      end else if (state == READY) begin
        if (clear_req) state <= DRAIN;
      end else if (pending == '0) state <= CLEAR;
      if ((rd_acc | wr_acc) & (oor | both)) err_sticky <= 1'b1;
    end
  mem_read_pipe #(.LATENCY(READ_LATENCY), .MAX_PENDING(MAX_PENDING)) u_pipe (
    .clock         (clock),
    .reset         (reset),
    .push          (rd_acc & ~slave_write),
    .push_data     (oor ? '0 : mem[idx]),
    .readdatavalid (slave_readdatavalid),
    .readdata      (slave_readdata),
    .pending       (pending)
  );
endmodule

// File: doc/avalon_mem_responder.md
Name: avalon_mem_responder

Overview:
- Avalon-MM slave that answers one rasterizer master port (vertex fetch, depth fetch or z-test write-back), backed by an on-chip word RAM.
- Provides fixed-latency pipelined reads, byte-enabled writes and waitrequest backpressure.
- Provides a bulk-clear engine for depth/colour buffers.
- Serves as the synthesizable stand-in for SDRAM in bring-up and as the memory model in pipeline benches.

Parameters:
- DEPTH_LOG2, 12, RAM holds 2**DEPTH_LOG2 32-bit words.
- READ_LATENCY, 2, cycles from read acceptance to readdatavalid (1..8).
- MAX_PENDING, 2, maximum reads in flight (1..READ_LATENCY).
- CLEAR_VALUE, 32'h7FFF_FFFF, word written by the clear engine (far depth).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- slave_address  in  26  byte address; word index = slave_address[DEPTH_LOG2+1:2].
- slave_read  in  1  read request.
- slave_write  in  1  write request.
- slave_byteenable  in  4  write byte lanes.
- slave_writedata  in  32  write data.
- slave_readdata  out  32  read data, valid with slave_readdatavalid.
- slave_readdatavalid  out  1  one-cycle pulse per accepted read.
- slave_waitrequest  out  1  request not accepted this cycle.
- force_wait  in  1  bench/debug: forces waitrequest high.
- clear_req  in  1  one-cycle pulse: fill RAM with CLEAR_VALUE.
- clear_busy  out  1  high while state is DRAIN or CLEAR.
- err_sticky  out  1  protocol/range error seen since reset.

Behaviour:
- Reset: outputs readdata=0, readdatavalid=0, err_sticky=0, waitrequest=1, clear_busy=1. State enters CLEAR, clear pointer=0, read pipeline flushed. Reset mid-read drops in-flight reads; no readdatavalid is produced for them.
- States:
  - CLEAR: writes CLEAR_VALUE to word[ptr]; ptr++ each cycle. After the last word (ptr = 2**DEPTH_LOG2-1), go to READY. Takes exactly 2**DEPTH_LOG2 cycles.
  - READY: serves requests.
  - DRAIN: waits until the pending count is 0, then goes to CLEAR with ptr=0.
- clear_req in READY → DRAIN next cycle. clear_req in DRAIN or CLEAR is ignored (no restart).
- waitrequest = (state != READY) | force_wait | (slave_read & pending == MAX_PENDING). It is combinational from the inputs and the current count.
- Acceptance: request high and waitrequest low in the same cycle.
- Write accepted at T: only bytes with byteenable=1 are updated. The write is visible to a read accepted at T+1.
- Read accepted at T: slave_readdatavalid=1 at exactly T+READ_LATENCY, carrying the RAM contents as of T. Reads return in order; one read can be accepted per cycle.
- Pending count: +1 on read accept, -1 on readdatavalid; both in the same cycle leaves it unchanged. It never exceeds MAX_PENDING.
- slave_readdata holds its last value when readdatavalid=0.
- Out-of-range address (bits above DEPTH_LOG2+1 nonzero, within 26):
  - read is accepted and returns 0 with normal latency;
  - write is accepted and dropped;
  - both set err_sticky.
- slave_read & slave_write together: waitrequest follows the read rule. If accepted, neither operation executes, no readdatavalid is produced, and err_sticky is set.
- Address bits [1:0] are ignored.

Decomposition:
- Shared package rast_mem_pkg:
  - state enum mem_state_t {CLEAR, READY, DRAIN};
  - default CLEAR_VALUE constant;
  - Avalon width constants (26-bit address, 32-bit data, 4-bit byteenable), shared with the rasterizer master blocks.
- One sub-module: mem_read_pipe. It is a READ_LATENCY-deep valid/data shift register with the pending counter, and outputs readdatavalid/readdata.
- The RAM is an inferred array in the top module, with per-byte write enables.

Test Plan:
- Reset, then hold clear_busy until it drops (exactly 4096 cycles at default) → any read returns 32'h7FFF_FFFF; err_sticky=0.
- Write 0xDEADBEEF to address 0x10 with byteenable 4'b1111, then byteenable 4'b0010 with data 0x0000_5500 → read of 0x10 returns 0xDEAD55EF at accept+2.
- Back-to-back reads of 0x0, 0x4, 0x8 with readdata preloaded 1,2,3 → waitrequest never blocks (MAX_PENDING=2 balances latency 2); readdatavalid on 3 consecutive cycles returning 1,2,3 in order.
- Set MAX_PENDING=1, READ_LATENCY=3, issue continuous reads → waitrequest high while pending=1; one readdatavalid every 3 cycles; no read lost or duplicated.
- clear_req while 2 reads are in flight → both readdatavalid pulses still occur, then CLEAR. Requests stall with waitrequest=1 throughout, and memory reads CLEAR_VALUE afterwards.
- Read of address 0x0100_0000 (out of range) and simultaneous read+write → returns 0 after latency; err_sticky=1; memory unchanged.
